ext_int_ctrl: RTL and testbench

//  External interrupt controller: the source side of the core's machine external interrupt (mcause 0x8000000b).

---
 rtl/ext_int_ctrl.sv | 144 ++++++++++++++
 tb/tb_ext_int_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ext_int_ctrl.sv
// External interrupt controller: per-source level gateways, fixed-priority
// claim/complete handshake and a registered interrupt request to the CSR file.
module ext_int_ctrl #(
    parameter int NUM_SRC = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [3:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    input  logic               reg_we,
    input  logic               reg_re,
    output logic [31:0]        reg_rdata,
    output logic               int_req
);

    localparam logic [3:0] A_PEND = 4'h0;
    localparam logic [3:0] A_EN   = 4'h4;
    localparam logic [3:0] A_CLM  = 4'h8;
    localparam logic [3:0] A_STAT = 4'hC;

    typedef enum logic [1:0] {
        GW_IDLE = 2'd0,
        GW_PEND = 2'd1,
        GW_INFL = 2'd2
    } gw_e;

    gw_e                gw_q [NUM_SRC];
    logic [NUM_SRC-1:0] enable_q;
    logic [NUM_SRC-1:0] enable_d;
    logic [31:0]        rdata_q;
    logic [31:0]        rdata_d;
    logic               int_req_q;
    logic               int_req_d;

    logic [NUM_SRC-1:0] pend_vec;
    logic [NUM_SRC-1:0] infl_vec;
    logic [NUM_SRC-1:0] elig;
    logic [4:0]         win_idx;
    logic               win_vld;
    logic [4:0]         win_id;

    logic               claim_go;
    logic               cmpl_go;
    logic [4:0]         cmpl_id;
    logic               en_wr;
    logic               unused_wdata;

    assign unused_wdata = ^reg_wdata;

    always_comb begin
        pend_vec = '0;
        infl_vec = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            pend_vec[i] = (gw_q[i] == GW_PEND);
            infl_vec[i] = (gw_q[i] == GW_INFL);
        end
    end

    assign elig = pend_vec & enable_q;

    // Scan high-to-low so the lowest eligible index is the last one kept.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win_vld = 1'b1;
                win_idx = 5'(i);
            end
        end
    end

    assign win_id = win_vld ? (win_idx + 5'd1) : 5'd0;

    assign claim_go = reg_re && (reg_addr == A_CLM) && win_vld;
    assign cmpl_id  = reg_wdata[4:0];
    assign cmpl_go  = reg_we && (reg_addr == A_CLM)
                   && (cmpl_id != 5'd0)
                   && (cmpl_id <= 5'(NUM_SRC));
    assign en_wr    = reg_we && (reg_addr == A_EN);

    // Gateway FSMs; INFLIGHT ignores the line until completed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                gw_q[i] <= GW_IDLE;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                unique case (gw_q[i])
                    GW_IDLE: begin
                        if (irq_src[i]) gw_q[i] <= GW_PEND;
                    end
                    GW_PEND: begin
                        if (claim_go && (win_idx == 5'(i)))
                            gw_q[i] <= GW_INFL;
                    end
                    GW_INFL: begin
                        if (cmpl_go && (cmpl_id == 5'(i + 1)))
                            gw_q[i] <= GW_IDLE;
                    end
                    default: gw_q[i] <= GW_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        enable_d = enable_q;
        if (en_wr) enable_d = reg_wdata[NUM_SRC-1:0];
    end

    always_comb begin
        rdata_d = '0;
        if (reg_re) begin
            unique case (1'b1)
                (reg_addr == A_PEND): rdata_d = 32'(pend_vec);
                (reg_addr == A_EN):   rdata_d = 32'(enable_q);
                (reg_addr == A_CLM):  rdata_d = 32'(win_id);
                (reg_addr == A_STAT): rdata_d = 32'(infl_vec);
                default:              rdata_d = '0;
            endcase
        end
    end

    assign int_req_d = |elig;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            enable_q  <= '0;
            rdata_q   <= '0;
            int_req_q <= 1'b0;
        end else begin
            enable_q  <= enable_d;
            rdata_q   <= rdata_d;
            int_req_q <= int_req_d;
        end
    end

    assign reg_rdata = rdata_q;
    assign int_req   = int_req_q;

endmodule

// File: tb/tb_ext_int_ctrl.sv
// Bench for ext_int_ctrl: directed scenarios plus randomized traffic
// checked against a bitmask model of pending/in-flight/enable state.
module tb_ext_int_ctrl;

    logic        clock;
    logic        reset_n;
    logic [7:0]  irq_src;
    logic [3:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [31:0] reg_rdata;
    logic        int_req;

    int checks;
    int errors;

    logic [31:0] pend_m;
    logic [31:0] infl_m;
    logic [31:0] en_m;

    ext_int_ctrl #(.NUM_SRC(8)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .irq_src   (irq_src),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .int_req   (int_req)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        irq_src = '0;
        reg_we  = 1'b0;
        reg_re  = 1'b0;
        reset_n = 1'b0;
        #2;
        chk("rst_int_req", {31'b0, int_req}, 32'h0);
        chk("rst_rdata", reg_rdata, 32'h0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        pend_m = '0;
        infl_m = '0;
        en_m   = '0;
    endtask

    // One bus cycle: drive, predict from pre-edge model state, compare.
    task automatic cyc(input logic [7:0] irq, input logic we,
                       input logic re, input logic [3:0] addr,
                       input logic [31:0] wd);
        logic [31:0] elig;
        logic [31:0] w;
        logic [31:0] exp_rd;
        logic [31:0] idle_pre;
        logic [31:0] nxt_pend;
        logic [31:0] nxt_infl;
        logic        exp_int;
        int          id;
        irq_src   = irq;
        reg_we    = we;
        reg_re    = re;
        reg_addr  = addr;
        reg_wdata = wd;
        elig    = pend_m & en_m;
        exp_int = (elig != 0);
        w       = elig & (~elig + 32'd1);
        exp_rd  = '0;
        if (re) begin
            case (addr)
                4'h0: exp_rd = pend_m;
                4'h4: exp_rd = en_m;
                4'h8: begin
                    for (int i = 0; i < 32; i++)
                        if (w[i]) exp_rd = 32'(i + 1);
                end
                4'hC: exp_rd = infl_m;
                default: exp_rd = '0;
            endcase
        end
        idle_pre = ~(pend_m | infl_m) & 32'hFF;
        nxt_pend = pend_m;
        nxt_infl = infl_m;
        if (re && addr == 4'h8 && w != 0) begin
            nxt_pend = nxt_pend & ~w;
            nxt_infl = nxt_infl | w;
        end
        if (we && addr == 4'h8) begin
            id = int'(wd[4:0]);
            if (id >= 1 && id <= 8 && infl_m[id-1])
                nxt_infl[id-1] = 1'b0;
        end
        if (we && addr == 4'h4) en_m = wd & 32'hFF;
        nxt_pend = nxt_pend | ({24'h0, irq} & idle_pre);
        @(posedge clock);
        #1;
        pend_m = nxt_pend;
        infl_m = nxt_infl;
        chk("int_req", {31'b0, int_req}, {31'b0, exp_int});
        if (re) chk("rdata", reg_rdata, exp_rd);
    endtask

    initial begin
        logic [7:0]  ri;
        logic [31:0] rw;
        int          op;
        checks    = 0;
        errors    = 0;
        irq_src   = '0;
        reg_addr  = '0;
        reg_wdata = '0;
        reg_we    = 1'b0;
        reg_re    = 1'b0;
        reset_n   = 1'b0;
        pend_m    = '0;
        infl_m    = '0;
        en_m      = '0;
        @(posedge clock);
        #1;
        do_reset();

        // 1: pending while disabled, then enable
        cyc(8'h04, 0, 0, 4'h0, 0);
        cyc(8'h00, 0, 1, 4'h0, 0);
        chk("t1_pending", reg_rdata, 32'h4);
        cyc(8'h00, 0, 1, 4'h4, 0);
        cyc(8'h00, 1, 0, 4'h4, 32'h4);
        cyc(8'h00, 0, 0, 4'h0, 0);
        chk("t1_int_req", {31'b0, int_req}, 32'h1);
        cyc(8'h00, 0, 1, 4'h8, 0);
        chk("t1_claim", reg_rdata, 32'h3);
        cyc(8'h00, 1, 0, 4'h8, 32'h3);

        // 2: two sources, fixed priority
        cyc(8'h00, 1, 0, 4'h4, 32'hFF);
        cyc(8'h22, 0, 0, 4'h0, 0);
        cyc(8'h00, 0, 0, 4'h0, 0);
        cyc(8'h00, 0, 1, 4'h8, 0);
        chk("t2_claim_a", reg_rdata, 32'h2);
        cyc(8'h00, 0, 1, 4'h8, 0);
        chk("t2_claim_b", reg_rdata, 32'h6);
        cyc(8'h00, 0, 1, 4'h8, 0);
        chk("t2_claim_c", reg_rdata, 32'h0);
        chk("t2_int_low", {31'b0, int_req}, 32'h0);
        cyc(8'h00, 0, 1, 4'hC, 0);
        chk("t2_status", reg_rdata, 32'h22);
        cyc(8'h00, 1, 0, 4'h8, 32'h2);
        cyc(8'h00, 1, 0, 4'h8, 32'h6);

        // 3: held line re-arms two cycles after COMPLETE
        cyc(8'h01, 0, 0, 4'h0, 0);
        cyc(8'h01, 0, 0, 4'h0, 0);
        cyc(8'h01, 0, 1, 4'h8, 0);
        chk("t3_claim", reg_rdata, 32'h1);
        cyc(8'h01, 1, 0, 4'h8, 32'h1);
        cyc(8'h01, 0, 1, 4'h0, 0);
        chk("t3_pend_gap", reg_rdata, 32'h0);
        cyc(8'h00, 0, 1, 4'h0, 0);
        chk("t3_pend_set", reg_rdata, 32'h1);
        cyc(8'h00, 0, 0, 4'h0, 0);
        chk("t3_int_req", {31'b0, int_req}, 32'h1);
        cyc(8'h00, 0, 1, 4'h8, 0);
        cyc(8'h00, 1, 0, 4'h8, 32'h1);

        // 4: bogus completes are ignored
        cyc(8'h02, 0, 0, 4'h0, 0);
        cyc(8'h00, 0, 0, 4'h0, 0);
        cyc(8'h00, 0, 1, 4'h8, 0);
        cyc(8'h00, 1, 0, 4'h8, 32'h3);
        cyc(8'h00, 1, 0, 4'h8, 32'h1F);
        cyc(8'h00, 1, 0, 4'hC, 32'hFF);
        cyc(8'h00, 0, 1, 4'hC, 0);
        chk("t4_status", reg_rdata, 32'h2);
        cyc(8'h00, 0, 1, 4'h0, 0);
        chk("t4_pending", reg_rdata, 32'h0);
        cyc(8'h00, 1, 0, 4'h8, 32'h2);

        // 5: reset aborts an in-flight claim
        cyc(8'h08, 0, 0, 4'h0, 0);
        cyc(8'h00, 0, 0, 4'h0, 0);
        cyc(8'h00, 0, 1, 4'h8, 0);
        chk("t5_claim", reg_rdata, 32'h4);
        do_reset();
        cyc(8'h00, 0, 1, 4'hC, 0);
        cyc(8'h00, 0, 1, 4'h0, 0);
        cyc(8'h00, 0, 1, 4'h4, 0);
        chk("t5_enable", reg_rdata, 32'h0);

        // 6: rise during a claim is not claimable in that cycle
        cyc(8'h00, 1, 0, 4'h4, 32'hFF);
        cyc(8'h01, 0, 0, 4'h0, 0);
        cyc(8'h00, 0, 0, 4'h0, 0);
        cyc(8'h08, 0, 1, 4'h8, 0);
        chk("t6_claim_a", reg_rdata, 32'h1);
        cyc(8'h00, 0, 1, 4'h8, 0);
        chk("t6_claim_b", reg_rdata, 32'h4);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            if (n % 200 == 199) do_reset();
            ri = 8'($urandom & $urandom & $urandom);
            rw = $urandom;
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2: cyc(ri, 0, 1, 4'h8, 0);
                3:       cyc(ri, 0, 1, 4'($urandom_range(0, 15)), 0);
                4, 5:    cyc(ri, 1, 0, 4'h8,
                             32'($urandom_range(1, 8)));
                6:       cyc(ri, 1, 0, 4'h8, rw);
                7:       cyc(ri, 1, 0, 4'h4, rw);
                8:       cyc(ri, 1, 0, 4'($urandom_range(0, 15)), rw);
                default: cyc(ri, 0, 0, 4'h0, rw);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
